// File: rtl/sequenciador_calculadora.sv
`default_nettype none
// ============================================================================
// Module     : sequenciador_calculadora
// Description: Sequences one command at a time into an external combinational
//              calculator, waits ESPERA cycles, captures and delivers the result
//              with a valid/ready handshake. Optional flags: SEQUENCIADOR_FLAGS_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module sequenciador_calculadora #(
    parameter int ESPERA = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] op_A,
    input  logic [7:0] op_B,
    input  logic [2:0] op_codigo,
    output logic [7:0] calc_A,
    output logic [7:0] calc_B,
    output logic [2:0] calc_codigo,
    input  logic [7:0] calc_saida,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] resultado,
`ifdef SEQUENCIADOR_FLAGS_EN
    output logic       flag_zero,
    output logic       flag_codigo_invalido,
`endif
    output logic [7:0] contador
);

    localparam logic [3:0] c_espera = 4'(ESPERA);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EMITE   = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t    r_estado;
    estado_t    w_proximo;
    logic [3:0] r_espera;
    logic       w_aceita;
    logic       w_captura;
    logic       w_entrega;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = r_estado;
        w_aceita  = 1'b0;
        w_captura = 1'b0;
        w_entrega = 1'b0;
        case (r_estado)
            OCIOSO: begin
                if (in_valid) begin
                    w_aceita  = 1'b1;
                    w_proximo = EMITE;
                end
            end
            EMITE: begin
                // Capture on the last wait cycle so ESPERA=1 gives one-cycle latency.
                if (r_espera == 4'd1) begin
                    w_captura = 1'b1;
                    w_proximo = ENTREGA;
                end
            end
            ENTREGA: begin
                if (res_ready) begin
                    w_entrega = 1'b1;
                    w_proximo = OCIOSO;
                end
            end
            default: begin
                w_proximo = OCIOSO;
            end
        endcase
    end

    assign in_ready  = (r_estado == OCIOSO);
    assign res_valid = (r_estado == ENTREGA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            calc_A      <= 8'd0;
            calc_B      <= 8'd0;
            calc_codigo <= 3'd0;
            r_espera    <= 4'd0;
            resultado   <= 8'd0;
            contador    <= 8'd0;
        end else begin
            if (w_aceita) begin
                calc_A      <= op_A;
                calc_B      <= op_B;
                calc_codigo <= op_codigo;
                r_espera    <= c_espera;
            end else if (r_estado == EMITE) begin
                r_espera <= r_espera - 4'd1;
            end
            if (w_captura) begin
                resultado <= calc_saida;
            end
            if (w_entrega) begin
                contador <= contador + 8'd1;
            end
        end
    end

`ifdef SEQUENCIADOR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_zero            <= 1'b0;
            flag_codigo_invalido <= 1'b0;
        end else if (w_captura) begin
            flag_zero            <= (calc_saida == 8'd0);
            flag_codigo_invalido <= calc_codigo[2];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_calculadora.sv
`default_nettype none
// Testbench for sequenciador_calculadora: two instances (ESPERA=1 and ESPERA=4)
// driven by directed steps, with a result scoreboard queue.
module tb_sequenciador_calculadora;

    logic       clk;
    logic       rst_n;
    logic       in_valid_a;
    logic       in_valid_b;
    logic [7:0] op_A;
    logic [7:0] op_B;
    logic [2:0] op_codigo;
    logic       res_ready;
    logic       sel;

    logic       in_ready_a, in_ready_b;
    logic [7:0] calc_A_a, calc_A_b, calc_B_a, calc_B_b;
    logic [2:0] calc_codigo_a, calc_codigo_b;
    logic [7:0] calc_saida_a, calc_saida_b;
    logic       res_valid_a, res_valid_b;
    logic [7:0] resultado_a, resultado_b;
    logic [7:0] contador_a, contador_b;
`ifdef SEQUENCIADOR_FLAGS_EN
    logic       fz_a, fz_b, fci_a, fci_b;
`endif

    int         total;
    int         passed;
    int         failed;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic [7:0] exp_q[$];

    function automatic logic [7:0] calc(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a;
            3'b011:  return b;
            default: return 8'h00;
        endcase
    endfunction

    assign calc_saida_a = calc(calc_A_a, calc_B_a, calc_codigo_a);
    assign calc_saida_b = calc(calc_A_b, calc_B_b, calc_codigo_b);

    sequenciador_calculadora #(.ESPERA(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .op_A(op_A), .op_B(op_B), .op_codigo(op_codigo),
        .calc_A(calc_A_a), .calc_B(calc_B_a), .calc_codigo(calc_codigo_a),
        .calc_saida(calc_saida_a), .res_valid(res_valid_a), .res_ready(res_ready),
        .resultado(resultado_a),
`ifdef SEQUENCIADOR_FLAGS_EN
        .flag_zero(fz_a), .flag_codigo_invalido(fci_a),
`endif
        .contador(contador_a)
    );

    sequenciador_calculadora #(.ESPERA(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .op_A(op_A), .op_B(op_B), .op_codigo(op_codigo),
        .calc_A(calc_A_b), .calc_B(calc_B_b), .calc_codigo(calc_codigo_b),
        .calc_saida(calc_saida_b), .res_valid(res_valid_b), .res_ready(res_ready),
        .resultado(resultado_b),
`ifdef SEQUENCIADOR_FLAGS_EN
        .flag_zero(fz_b), .flag_codigo_invalido(fci_b),
`endif
        .contador(contador_b)
    );

    // Monitor view of whichever instance the current step targets.
    logic       m_in_ready, m_res_valid;
    logic [7:0] m_calc_A, m_calc_B, m_resultado, m_contador;
    logic [2:0] m_calc_codigo;
    assign m_in_ready    = sel ? in_ready_b    : in_ready_a;
    assign m_res_valid   = sel ? res_valid_b   : res_valid_a;
    assign m_calc_A      = sel ? calc_A_b      : calc_A_a;
    assign m_calc_B      = sel ? calc_B_b      : calc_B_a;
    assign m_calc_codigo = sel ? calc_codigo_b : calc_codigo_a;
    assign m_resultado   = sel ? resultado_b   : resultado_a;
    assign m_contador    = sel ? contador_b    : contador_a;
`ifdef SEQUENCIADOR_FLAGS_EN
    logic m_fz, m_fci;
    assign m_fz  = sel ? fz_b  : fz_a;
    assign m_fci = sel ? fci_b : fci_a;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iv(input logic v);
        if (sel) in_valid_b = v;
        else     in_valid_a = v;
    endtask

    // One command on the selected instance; hold>0 keeps res_ready low that many
    // cycles while a competing command is presented.
    task automatic do_cmd(input logic s, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] c, input logic [7:0] exp, input int lat,
                          input int hold);
        int         n;
        logic [7:0] esperado;
        sel       = s;
        op_A      = a;
        op_B      = b;
        op_codigo = c;
        res_ready = (hold == 0);
        set_iv(1'b1);
        exp_q.push_back(exp);
        step();
        set_iv(1'b0);
        check("accept_in_ready", m_in_ready, 0);
        check("accept_calc_A", m_calc_A, a);
        check("accept_calc_B", m_calc_B, b);
        check("accept_calc_codigo", m_calc_codigo, c);
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (m_res_valid) break;
        end
        check("latency", n, lat);
        esperado = exp_q.pop_front();
        check("resultado", m_resultado, esperado);
`ifdef SEQUENCIADOR_FLAGS_EN
        check("flag_zero", m_fz, (esperado == 8'h00));
        check("flag_codigo_invalido", m_fci, c[2]);
`endif
        for (int i = 0; i < hold; i++) begin
            op_A = ~a;
            op_B = ~b;
            op_codigo = 3'b001;
            set_iv(1'b1);
            step();
            check("hold_res_valid", m_res_valid, 1);
            check("hold_resultado", m_resultado, esperado);
            check("hold_in_ready", m_in_ready, 0);
            check("hold_calc_A", m_calc_A, a);
        end
        res_ready = 1'b1;
        step();
        set_iv(1'b0);
        if (s) cnt_b = cnt_b + 8'd1;
        else   cnt_a = cnt_a + 8'd1;
        check("contador", m_contador, s ? cnt_b : cnt_a);
        check("done_in_ready", m_in_ready, 1);
        check("done_res_valid", m_res_valid, 0);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic [2:0] rc;
        total = 0; passed = 0; failed = 0;
        cnt_a = 8'd0; cnt_b = 8'd0;
        sel = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        op_A = 8'd0; op_B = 8'd0; op_codigo = 3'd0;
        res_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready_a, 1);
        check("rst_res_valid", res_valid_a, 0);
        check("rst_resultado", resultado_a, 0);
        check("rst_calc_A", calc_A_a, 0);
        check("rst_contador", contador_a, 0);
        step();
        step();
        rst_n = 1'b1;

        do_cmd(1'b0, 8'h05, 8'h03, 3'b000, 8'h08, 1, 0);
        do_cmd(1'b0, 8'h03, 8'h05, 3'b001, 8'hFE, 1, 0);
        do_cmd(1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 1, 0);
        do_cmd(1'b0, 8'h10, 8'h20, 3'b000, 8'h30, 1, 5);
        do_cmd(1'b0, 8'hEF, 8'hDF, 3'b001, 8'h10, 1, 0);

        // Reset during EMITE on the ESPERA=4 instance aborts the command.
        sel = 1'b1;
        op_A = 8'h5A; op_B = 8'hA5; op_codigo = 3'b000;
        in_valid_b = 1'b1;
        step();
        in_valid_b = 1'b0;
        step();
        check("emite_res_valid", res_valid_b, 0);
        #3 rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready_b, 1);
        check("abort_res_valid", res_valid_b, 0);
        check("abort_resultado", resultado_b, 0);
        check("abort_calc_A", calc_A_b, 0);
        check("abort_calc_B", calc_B_b, 0);
        check("abort_calc_codigo", calc_codigo_b, 0);
        check("abort_contador", contador_b, 0);
        step();
        rst_n = 1'b1;
        cnt_a = 8'd0;
        cnt_b = 8'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_abort_res_valid", res_valid_b, 0);
        end

        do_cmd(1'b1, 8'h11, 8'h7A, 3'b011, 8'h7A, 4, 0);
        do_cmd(1'b1, 8'h22, 8'h33, 3'b110, 8'h00, 4, 0);

        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 3'($urandom_range(0, 7));
            do_cmd(1'b0, ra, rb, rc, calc(ra, rb, rc), 1, 0);
        end
        check("wrap_contador", contador_a, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
